// File: rtl/bpred_pkg.sv
// bpred_pkg: shared counter constants, FSM states and result-queue entry for the branch predictor updater
package bpred_pkg;
    localparam int DEF_LOG2TABLEDEPTH = 12;
    localparam int CTR_W = 2;
    typedef logic [CTR_W-1:0] ctr_t;
    localparam ctr_t CTR_INIT = 2'b01;
    localparam ctr_t CTR_MAX  = 2'b11;
    localparam ctr_t CTR_MIN  = 2'b00;
    typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;
    typedef struct packed {
        logic [DEF_LOG2TABLEDEPTH-1:0] index;
        logic                          result;
    } fifo_entry_t;
    function automatic ctr_t sat_inc(ctr_t c);
        return (c == CTR_MAX) ? c : c + ctr_t'(1);
    endfunction
    function automatic ctr_t sat_dec(ctr_t c);
        return (c == CTR_MIN) ? c : c - ctr_t'(1);
    endfunction
endpackage

// File: rtl/bpred_result_fifo.sv
// bpred_result_fifo: small synchronous queue of resolved branches; a push into a full queue is taken when a pop frees a slot the same cycle
module bpred_result_fifo
    import bpred_pkg::*;
#(
    parameter int LOG2DEPTH = 2,
    parameter int DEPTH     = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  fifo_entry_t        din,
    output logic               full,
    output logic               empty,
    output logic [LOG2DEPTH:0] count,
    output fifo_entry_t        head
);
    fifo_entry_t          mem [DEPTH];
    logic [LOG2DEPTH-1:0] wr_ptr;
    logic [LOG2DEPTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = count == (LOG2DEPTH+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + LOG2DEPTH'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + LOG2DEPTH'(1) : rd_ptr;
            count  <= count + (LOG2DEPTH+1)'(do_push) - (LOG2DEPTH+1)'(do_pop);
        end
    end

    // storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/bpred_update_ctrl.sv
// bpred_update_ctrl: clears the 2-bit counter table after reset/flush, then applies queued branch outcomes
// as read-modify-write updates on table port A (one update every two cycles).
module bpred_update_ctrl
    import bpred_pkg::*;
#(
    parameter int PCWIDTH        = 32,
    parameter int LOG2TABLEDEPTH = DEF_LOG2TABLEDEPTH,
    parameter int TABLEDEPTH     = 2**LOG2TABLEDEPTH,
    parameter int CTRWIDTH       = CTR_W,
    parameter int LOG2FIFODEPTH  = 2,
    parameter int FIFODEPTH      = 2**LOG2FIFODEPTH
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      result_rdy,
    input  logic                      result,
    input  logic [PCWIDTH-1:0]        pc_result,
    input  logic                      flush,
    output logic [LOG2TABLEDEPTH-1:0] tbl_addr_a,
    output logic                      tbl_wren_a,
    output logic [CTRWIDTH-1:0]       tbl_data_a,
    input  logic [CTRWIDTH-1:0]       tbl_q_a,
    output logic                      init_busy,
    output logic                      overflow,
    input  logic                      overflow_clr
);
    state_t                    state;
    state_t                    state_nxt;
    logic [LOG2TABLEDEPTH-1:0] clr_ptr;
    logic                      push;
    logic                      pop;
    logic                      drop;
    logic                      full;
    logic                      empty;
    logic [LOG2FIFODEPTH:0]    count;
    fifo_entry_t               entry;
    fifo_entry_t               head;
    ctr_t                      upd;
    logic                      unused_pc;

    assign unused_pc   = ^{pc_result[PCWIDTH-1:LOG2TABLEDEPTH+2], pc_result[1:0]};
    assign entry.index = pc_result[LOG2TABLEDEPTH+1:2];
    assign entry.result = result;

    // flush discards the incoming result and cancels the pending pop
    assign push = result_rdy & ~flush;
    assign pop  = (state == WRITE) & ~flush;
    assign drop = push & full & ~pop;

    bpred_result_fifo #(
        .LOG2DEPTH(LOG2FIFODEPTH),
        .DEPTH    (FIFODEPTH)
    ) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= INIT;
            clr_ptr  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_ptr  <= flush ? '0 : (state == INIT) ? clr_ptr + LOG2TABLEDEPTH'(1) : clr_ptr;
            overflow <= drop ? 1'b1 : overflow_clr ? 1'b0 : overflow;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = (clr_ptr == LOG2TABLEDEPTH'(TABLEDEPTH-1)) ? IDLE : INIT;
            IDLE:    state_nxt = empty ? IDLE : READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (count > (LOG2FIFODEPTH+1)'(1) || push) ? READ : IDLE;
            default: state_nxt = INIT;
        endcase
        if (flush) state_nxt = INIT;
    end

    // port A read data arrives in WRITE for the address presented in READ
    assign upd        = head.result ? sat_inc(tbl_q_a) : sat_dec(tbl_q_a);
    assign init_busy  = state == INIT;
    assign tbl_addr_a = (state == READ || state == WRITE) ? head.index : clr_ptr;
    assign tbl_wren_a = resetn & ((state == INIT) | ((state == WRITE) & ~flush));
    assign tbl_data_a = !resetn ? '0 : (state == INIT) ? CTR_INIT : (state == WRITE) ? upd : '0;
endmodule
